// File: rtl/fsm_uart_pkg.sv
// Shared definitions for the UART framing FSMs (receive framer and transmit sequencer).
package fsm_uart_pkg;

   // Default width of one UART byte.
   localparam int unsigned UART_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_FULL = 2'd2
   } state_e;

   // Bits needed to index 'value' entries; never less than one bit.
   function automatic int unsigned clogb2(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fsm_uart_rx_timer.sv
// Inter-byte idle timer for fsm_uart_rx; only built with FSM_UART_RX_TIMEOUT_EN.
module fsm_uart_rx_timer
   import fsm_uart_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int unsigned    TW   = clogb2(TIMEOUT);
   localparam logic [TW-1:0]  LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmr_q, tmr_d;

   // Count enabled cycles, holding at the terminal value until cleared.
   always_comb begin
      tmr_d = tmr_q;
      if (i_clr) begin
         tmr_d = '0;
      end else if (i_en && (tmr_q != LAST)) begin
         tmr_d = tmr_q + TW'(1);
      end
   end

   // Timer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end

   assign o_expire = i_en && (tmr_q == LAST);

endmodule

// File: rtl/fsm_uart_rx.sv
// Receive framer: packs N UART bytes into one frame and hands it over with valid/ready.
// Optional inter-byte timeout enabled by defining FSM_UART_RX_TIMEOUT_EN.
module fsm_uart_rx
   import fsm_uart_pkg::*;
#(
   parameter int unsigned N       = 16,
   parameter int unsigned W       = UART_W,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_clr,
   input  logic                       i_rx_valid,
   input  logic [W-1:0]               i_rx_data,
   input  logic                       i_frame_ready,
   output logic [N*W-1:0]             o_frame,
   output logic                       o_frame_valid,
   output logic [clogb2(N-1)-1:0]     o_sel,
   output logic                       o_busy,
   output logic                       o_overrun,
   output logic                       o_timeout
);

   localparam int unsigned   CW   = clogb2(N);
   localparam int unsigned   SW   = clogb2(N - 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N*W-1:0]    frame_q, frame_d;
   logic              overrun_q, overrun_d;
   logic              timeout_q, timeout_d;
   logic              tmr_expire;

`ifdef FSM_UART_RX_TIMEOUT_EN
   fsm_uart_rx_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    ((state_q != ST_RECV) || i_rx_valid),
      .i_en     (state_q == ST_RECV),
      .o_expire (tmr_expire)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmr_expire     = 1'b0;
`endif

   // Next-state logic: byte packing, frame hand-off, overrun and timeout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      frame_d   = frame_q;
      overrun_d = overrun_q;
      timeout_d = 1'b0;
      if (i_clr) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         overrun_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_rx_valid) begin
                  frame_d[W-1:0] = i_rx_data;
                  state_d        = (N == 1) ? ST_FULL : ST_RECV;
                  cnt_d          = (N == 1) ? '0 : CW'(1);
               end
            end
            ST_RECV: begin
               if (i_rx_valid) begin
                  frame_d[32'(cnt_q) * W +: W] = i_rx_data;
                  if (cnt_q == LAST) begin
                     state_d = ST_FULL;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (tmr_expire) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
               end
            end
            ST_FULL: begin
               if (i_frame_ready) begin
                  // A byte arriving with ready becomes slot 0 of the next frame.
                  if (i_rx_valid) begin
                     frame_d[W-1:0] = i_rx_data;
                     state_d        = (N == 1) ? ST_FULL : ST_RECV;
                     cnt_d          = (N == 1) ? '0 : CW'(1);
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (i_rx_valid) begin
                  overrun_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         frame_q   <= '0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         frame_q   <= frame_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_frame       = frame_q;
   assign o_frame_valid = (state_q == ST_FULL);
   assign o_sel         = cnt_q[SW-1:0];
   assign o_busy        = (state_q != ST_IDLE);
   assign o_overrun     = overrun_q;
   assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_fsm_uart_rx.sv
// Bench for fsm_uart_rx: an N=4 and an N=1 instance, a frame-level reference model
// checked every cycle, plus directed hand-computed expectations.
module tb_fsm_uart_rx;

   localparam int unsigned W  = 8;
   localparam int unsigned TO = 8;
`ifdef FSM_UART_RX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // N=4 instance
   logic        a_clr = 1'b0, a_vld = 1'b0, a_rdy = 1'b0;
   logic [7:0]  a_data = '0;
   logic [31:0] a_frame;
   logic        a_fv, a_busy, a_ovr, a_to;
   logic [1:0]  a_sel;

   // N=1 instance
   logic        b_clr = 1'b0, b_vld = 1'b0, b_rdy = 1'b0;
   logic [7:0]  b_data = '0;
   logic [7:0]  b_frame;
   logic        b_fv, b_busy, b_ovr, b_to;
   logic [0:0]  b_sel;

   fsm_uart_rx #(.N(4), .W(W), .TIMEOUT(TO)) dut_a (
      .clk           (clk),
      .rst           (rst),
      .i_clr         (a_clr),
      .i_rx_valid    (a_vld),
      .i_rx_data     (a_data),
      .i_frame_ready (a_rdy),
      .o_frame       (a_frame),
      .o_frame_valid (a_fv),
      .o_sel         (a_sel),
      .o_busy        (a_busy),
      .o_overrun     (a_ovr),
      .o_timeout     (a_to)
   );

   fsm_uart_rx #(.N(1), .W(W), .TIMEOUT(TO)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .i_clr         (b_clr),
      .i_rx_valid    (b_vld),
      .i_rx_data     (b_data),
      .i_frame_ready (b_rdy),
      .o_frame       (b_frame),
      .o_frame_valid (b_fv),
      .o_sel         (b_sel),
      .o_busy        (b_busy),
      .o_overrun     (b_ovr),
      .o_timeout     (b_to)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
   endtask

   // Frame-level model: bytes collected so far, whether a finished frame is held,
   // sticky overrun, and empty cycles waited since the last byte.
   logic [31:0] m_frame [2];
   bit          m_held  [2];
   int          m_cnt   [2];
   bit          m_ovr   [2];
   bit          m_to    [2];
   int          m_wait  [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_frame[i] = '0; m_held[i] = 0; m_cnt[i] = 0;
         m_ovr[i] = 0; m_to[i] = 0; m_wait[i] = 0;
      end
   endtask

   task automatic model_step(input int id, input int n, input logic clr, input logic vld,
                             input logic [7:0] data, input logic rdy);
      bit take;
      m_to[id] = 0;
      if (clr) begin
         m_held[id] = 0; m_cnt[id] = 0; m_ovr[id] = 0; m_wait[id] = 0;
      end else begin
         take = vld && (!m_held[id] || rdy);
         if (m_held[id] && vld && !rdy) m_ovr[id] = 1;
         if (m_held[id] && rdy) m_held[id] = 0;
         if (take) begin
            m_frame[id][m_cnt[id]*8 +: 8] = data;
            m_cnt[id]++;
            m_wait[id] = 0;
            if (m_cnt[id] == n) begin
               m_held[id] = 1;
               m_cnt[id]  = 0;
            end
         end else if (TO_EN && m_cnt[id] > 0) begin
            m_wait[id]++;
            if (m_wait[id] == TO) begin
               m_cnt[id]  = 0;
               m_to[id]   = 1;
               m_wait[id] = 0;
            end
         end
      end
   endtask

   // Advance the model on every edge and compare shortly after it.
   always @(posedge clk) begin
      if (!rst) model_reset();
      else begin
         model_step(0, 4, a_clr, a_vld, a_data, a_rdy);
         model_step(1, 1, b_clr, b_vld, b_data, b_rdy);
      end
      #1;
      check("cmp A frame",   a_frame, m_frame[0]);
      check("cmp A valid",   32'(a_fv), 32'(m_held[0]));
      check("cmp A sel",     32'(a_sel), 32'(m_cnt[0]));
      check("cmp A busy",    32'(a_busy), 32'(m_held[0] || m_cnt[0] > 0));
      check("cmp A overrun", 32'(a_ovr), 32'(m_ovr[0]));
      check("cmp A timeout", 32'(a_to), 32'(m_to[0]));
      check("cmp B frame",   32'(b_frame), 32'(m_frame[1][7:0]));
      check("cmp B valid",   32'(b_fv), 32'(m_held[1]));
      check("cmp B sel",     32'(b_sel), 32'(m_cnt[1]));
      check("cmp B busy",    32'(b_busy), 32'(m_held[1] || m_cnt[1] > 0));
      check("cmp B overrun", 32'(b_ovr), 32'(m_ovr[1]));
      check("cmp B timeout", 32'(b_to), 32'(m_to[1]));
   end

   task automatic a_send(input logic [7:0] d, input logic rdy);
      a_vld = 1'b1; a_data = d; a_rdy = rdy;
      @(negedge clk);
      a_vld = 1'b0; a_rdy = 1'b0;
   endtask

   task automatic a_send4(input logic [31:0] f);
      for (int i = 0; i < 4; i++) a_send(f[i*8 +: 8], 1'b0);
   endtask

   task automatic a_release();
      a_rdy = 1'b1;
      @(negedge clk);
      a_rdy = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         first;
      int         pulses;
      logic [7:0] d;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst frame", a_frame, 32'h0);
      check("rst valid", 32'(a_fv), 0);
      check("rst busy", 32'(a_busy), 0);
      check("rst sel", 32'(a_sel), 0);
      check("rst overrun", 32'(a_ovr), 0);
      check("rst timeout", 32'(a_to), 0);
      rst = 1'b1;

      // 1: four bytes assemble into one frame
      a_send(8'h11, 1'b0); a_send(8'h22, 1'b0); a_send(8'h33, 1'b0);
      check("t1 sel before last", 32'(a_sel), 3);
      check("t1 valid before last", 32'(a_fv), 0);
      a_send(8'h44, 1'b0);
      check("t1 valid", 32'(a_fv), 1);
      check("t1 frame", a_frame, 32'h44332211);
      check("t1 sel", 32'(a_sel), 0);
      repeat (3) @(negedge clk);
      check("t1 held valid", 32'(a_fv), 1);
      check("t1 held frame", a_frame, 32'h44332211);
      a_release();
      check("t1 valid drop", 32'(a_fv), 0);
      check("t1 idle busy", 32'(a_busy), 0);
      check("t1 frame kept", a_frame, 32'h44332211);

      // 2: overrun while held, then clear
      a_send4(32'h44332211);
      a_send(8'h55, 1'b0);
      check("t2 overrun", 32'(a_ovr), 1);
      check("t2 frame unchanged", a_frame, 32'h44332211);
      @(negedge clk);
      check("t2 overrun sticky", 32'(a_ovr), 1);
      a_clr = 1'b1; @(negedge clk); a_clr = 1'b0;
      check("t2 clr overrun", 32'(a_ovr), 0);
      check("t2 clr valid", 32'(a_fv), 0);
      check("t2 clr busy", 32'(a_busy), 0);
      check("t2 clr frame kept", a_frame, 32'h44332211);

      // 3: ready and byte together start the next frame
      a_send4(32'h44332211);
      a_send(8'hA0, 1'b1);
      check("t3 valid", 32'(a_fv), 0);
      check("t3 sel", 32'(a_sel), 1);
      check("t3 busy", 32'(a_busy), 1);
      check("t3 slot0", 32'(a_frame[7:0]), 32'hA0);
      a_send(8'hA1, 1'b0); a_send(8'hA2, 1'b0); a_send(8'hA3, 1'b0);
      check("t3 frame", a_frame, 32'hA3A2A1A0);
      check("t3 frame valid", 32'(a_fv), 1);
      a_release();

      // 4: asynchronous reset mid-frame
      a_send(8'h5A, 1'b0); a_send(8'h6B, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("t4 async frame", a_frame, 32'h0);
      check("t4 async busy", 32'(a_busy), 0);
      check("t4 async sel", 32'(a_sel), 0);
      check("t4 async valid", 32'(a_fv), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      a_send4(32'hC3C2C1C0);
      check("t4 frame after reset", a_frame, 32'hC3C2C1C0);
      check("t4 valid after reset", 32'(a_fv), 1);
      a_release();

      // 5: inter-byte timeout
`ifdef FSM_UART_RX_TIMEOUT_EN
      a_send(8'h77, 1'b0);
      first = 0; pulses = 0;
      for (int j = 1; j <= 12; j++) begin
         if (a_to) begin
            pulses++;
            if (first == 0) first = j;
         end
         @(negedge clk);
      end
      check("t5 pulse position", 32'(first), 9);
      check("t5 pulse count", 32'(pulses), 1);
      check("t5 busy after", 32'(a_busy), 0);
      check("t5 sel after", 32'(a_sel), 0);
      a_send(8'h88, 1'b0);
      repeat (7) @(negedge clk);
      a_send(8'h99, 1'b0);
      check("t5 terminal timeout", 32'(a_to), 0);
      check("t5 terminal sel", 32'(a_sel), 2);
      check("t5 terminal busy", 32'(a_busy), 1);
`else
      a_send(8'h77, 1'b0);
      first = 0; pulses = 0;
      repeat (20) @(negedge clk);
      check("t5 wait busy", 32'(a_busy), 1);
      check("t5 wait sel", 32'(a_sel), 1);
      check("t5 wait timeout", 32'(a_to), 0);
`endif
      a_clr = 1'b1; @(negedge clk); a_clr = 1'b0;

      // 6: N=1 delivers every byte
      b_vld = 1'b1; b_data = 8'h3C; @(negedge clk); b_vld = 1'b0;
      check("t6 valid", 32'(b_fv), 1);
      check("t6 frame", 32'(b_frame), 32'h3C);
      check("t6 sel", 32'(b_sel), 0);
      b_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d = 8'h10 + 8'(i);
         b_vld = 1'b1; b_data = d;
         @(negedge clk);
         check("t6 stream frame", 32'(b_frame), 32'(d));
         check("t6 stream valid", 32'(b_fv), 1);
         check("t6 stream overrun", 32'(b_ovr), 0);
      end
      b_vld = 1'b0;
      @(negedge clk);
      b_rdy = 1'b0;
      check("t6 drained valid", 32'(b_fv), 0);
      check("t6 drained overrun", 32'(b_ovr), 0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
